// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU, DMA) arbiter onto a single unified memory with fixed read latency.
// CPU has priority; a starvation counter forces a DMA grant after STARVE_LIMIT CPU wins.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int LW = 3;
    localparam int SW = 4;
    localparam logic [LW-1:0] LAT_INIT   = LW'(READ_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE,
        S_READ_WAIT
    } state_t;

    state_t                r_state;
    logic [LW-1:0]         r_lat_cnt;
    logic [SW-1:0]         r_starve_cnt;
    logic                  r_owner_dma;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rvalid_pend;

    logic                  w_idle;
    logic                  w_dma_wins;
    logic                  w_cpu_gnt;
    logic                  w_dma_gnt;
    logic                  w_any_gnt;
    logic                  w_gnt_we;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [DATA_WIDTH-1:0] w_gnt_wdata;

    // Grants are combinational so a write completes in the cycle it is granted;
    // gating with rst keeps every grant low the instant reset rises.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_dma_wins  = bus.dma_req && (r_starve_cnt == STARVE_MAX);
    assign w_cpu_gnt   = w_idle && bus.cpu_req && !w_dma_wins;
    assign w_dma_gnt   = w_idle && bus.dma_req && (w_dma_wins || !bus.cpu_req);
    assign w_any_gnt   = w_cpu_gnt || w_dma_gnt;
    assign w_gnt_we    = w_dma_gnt ? bus.dma_we    : bus.cpu_we;
    assign w_gnt_addr  = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
    assign w_gnt_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.mem_we    = w_any_gnt && w_gnt_we;
    assign bus.mem_addr  = w_any_gnt ? w_gnt_addr : r_addr;
    assign bus.mem_wdata = w_any_gnt ? w_gnt_wdata : '0;

    // Read data passes straight through; only the owner's valid is raised.
    assign bus.cpu_rvalid = r_rvalid_pend && !r_owner_dma;
    assign bus.dma_rvalid = r_rvalid_pend && r_owner_dma;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_rdata  = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lat_cnt     <= '0;
            r_starve_cnt  <= '0;
            r_owner_dma   <= 1'b0;
            r_addr        <= '0;
            r_rvalid_pend <= 1'b0;
        end else begin
            r_rvalid_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_gnt && !w_gnt_we) begin
                        r_addr      <= w_gnt_addr;
                        r_owner_dma <= w_dma_gnt;
                        if (READ_LATENCY == 1) begin
                            r_rvalid_pend <= 1'b1;
                        end else begin
                            r_lat_cnt <= LAT_INIT;
                            r_state   <= S_READ_WAIT;
                        end
                    end
                end
                S_READ_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - LW'(1);
                    // Leaving now lands the return cycle on the next IDLE cycle.
                    if (r_lat_cnt == LW'(1)) begin
                        r_state       <= S_IDLE;
                        r_rvalid_pend <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (!bus.dma_req || w_dma_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_cpu_gnt && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory between the multicycle CPU port (driven by the control unit's IorD/MemWrite sequencing) and a DMA/loader port. It grants one access at a time, issues it to memory, and tracks read latency so each read returns data to its own requester. A starvation counter bounds how long DMA waits behind CPU fetches.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width
READ_LATENCY, 2, cycles from read issue to valid mem_rdata (legal 1..4)
STARVE_LIMIT, 4, consecutive CPU grants with DMA pending before DMA is forced to win (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  CPU read data valid, 1-cycle pulse
cpu_rdata  out  DATA_WIDTH  CPU read data
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same semantics, DMA port
dma_gnt, dma_rvalid  out  1  same semantics, DMA port
dma_rdata  out  DATA_WIDTH  DMA read data
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after issue

Behaviour:
- Reset (async, immediate): state IDLE, lat_cnt=0, starve_cnt=0, owner=CPU, held address=0; all gnt/rvalid/mem_we=0, mem_addr=0, mem_wdata=0. Reset during READ_WAIT aborts the read; no rvalid is produced.
- States: IDLE, READ_WAIT.
- IDLE, no req: mem_we=0, mem_addr=held address, no gnt.
- IDLE, any req: choose winner; assert winner's gnt combinationally in the same cycle; drive mem_addr/mem_wdata/mem_we from the winner. The loser sees no gnt and must keep req and its fields stable.
  - Write: completes in the grant cycle (mem_we=1 for exactly that cycle); stay IDLE.
  - Read: latch addr and owner; lat_cnt<=READ_LATENCY-1; go to READ_WAIT (READ_LATENCY=1 returns to IDLE directly with the rvalid pending).
- Arbitration: CPU wins by default. If dma_req=1 and starve_cnt==STARVE_LIMIT, DMA wins.
- starve_cnt: +1 on each CPU grant while dma_req=1; cleared on DMA grant or whenever dma_req=0; saturates at STARVE_LIMIT.
- READ_WAIT: mem_addr=latched address, mem_we=0, no grants. lat_cnt decrements each cycle; at 0 return to IDLE.
- Read return: for an issue at cycle T, the owner's rvalid=1 for exactly cycle T+READ_LATENCY; owner's rdata=mem_rdata in that cycle. The same cycle is IDLE, so a new grant may coincide with the rvalid (back-to-back reads, one issue per READ_LATENCY cycles).
- rdata outputs are don't-care when rvalid=0; the non-owner's rvalid stays 0.
- A req deasserted before its gnt is legal and is simply dropped. Both reqs arriving in the same cycle is resolved by the arbitration rule above.
- No buffering: at most one outstanding read. Throughput is 1 write/cycle or 1 read per READ_LATENCY cycles.

Test Plan:
- CPU write alone, addr=0x10, wdata=0xDEADBEEF -> cpu_gnt=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF in the same cycle; next cycle mem_we=0, still IDLE.
- CPU read alone, addr=0x20, memory model returns 0x12345678 at latency 2: gnt at T; mem_addr=0x20 at T and T+1; cpu_rvalid=1 with cpu_rdata=0x12345678 only at T+2; dma_rvalid stays 0.
- Both reqs held high for 12 write cycles, STARVE_LIMIT=4 -> grant order C,C,C,C,D repeating; mem_we=1 every cycle; never both gnts high.
- CPU read issued at T, dma_req raised at T+1 -> no dma_gnt at T+1; at T+2 cpu_rvalid=1 and dma_gnt=1 together.
- rst pulsed mid-cycle at T+1 of a CPU read -> outputs go to 0 immediately without a clock edge; no cpu_rvalid at T+2; after release, the first arbitration gives CPU priority (starve_cnt=0).
- READ_LATENCY=1, DMA read alone at addr 0x40 -> dma_gnt at T, dma_rvalid at T+1; DMA read at T+1 also granted (back-to-back).
